pdp_mem_arbiter: RTL

- Arbitrates the single PDP8 memory port between three requesters: instruction-fetch read (IFU), execute-unit read and execute-unit write.
- Sits between instr_decode/instr_exec and memory_pdp.
- Serialises accesses through one memory port with fixed-priority arbitration and IFU anti-starvation aging.
- Returns read data to the requester that issued the read.

---
 rtl/pdp_mem_arbiter_if.sv | 47 ++++
 rtl/pdp_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pdp_mem_arbiter_if.sv
// Requester and memory-side bus of the PDP8 memory-port arbiter.
// The master modport is the requesters and the memory; the slave modport is the arbiter.
interface pdp_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic                  ifu_rd_gnt;
  logic                  ifu_rd_valid;
  logic [DATA_WIDTH-1:0] ifu_rd_data;

  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic                  exec_rd_gnt;
  logic                  exec_rd_valid;
  logic [DATA_WIDTH-1:0] exec_rd_data;

  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  exec_wr_gnt;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport master (
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, mem_rdata,
    input  ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
           exec_rd_gnt, exec_rd_valid, exec_rd_data, exec_wr_gnt,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, mem_rdata,
    output ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
           exec_rd_gnt, exec_rd_valid, exec_rd_data, exec_wr_gnt,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/pdp_mem_arbiter.sv
// PDP8 single memory-port arbiter: exec write > exec read > IFU read, with IFU aging.
// Optional grant/conflict counters are enabled by defining PDP_ARB_PERF_CNT_EN.
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic clk,
  input  logic reset,
`ifdef PDP_ARB_PERF_CNT_EN
  output logic [31:0] ifu_gnt_cnt,
  output logic [31:0] exec_rd_gnt_cnt,
  output logic [31:0] exec_wr_gnt_cnt,
  output logic [31:0] conflict_cnt,
`endif
  pdp_mem_arbiter_if.slave bus
);

  localparam int LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  localparam logic [1:0] ID_IFU  = 2'd0;
  localparam logic [1:0] ID_EXRD = 2'd1;
  localparam logic [1:0] ID_EXWR = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [1:0]            id_r;
  logic [LAT_W-1:0]      lat_cnt_r;
  logic [WAIT_W-1:0]     wait_cnt_r;

  logic                  starve_s;
  logic                  win_valid_s;
  logic [1:0]            win_id_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic                  rd_done_s;

  // Winner selection for the current IDLE cycle; aging overrides fixed priority.
  always_comb begin
    starve_s    = bus.ifu_rd_req && (wait_cnt_r >= WAIT_W'(MAX_WAIT));
    win_valid_s = 1'b1;
    win_id_s    = ID_IFU;
    win_addr_s  = bus.ifu_rd_addr;
    if (starve_s) begin
      win_id_s   = ID_IFU;
      win_addr_s = bus.ifu_rd_addr;
    end else if (bus.exec_wr_req) begin
      win_id_s   = ID_EXWR;
      win_addr_s = bus.exec_wr_addr;
    end else if (bus.exec_rd_req) begin
      win_id_s   = ID_EXRD;
      win_addr_s = bus.exec_rd_addr;
    end else if (bus.ifu_rd_req) begin
      win_id_s   = ID_IFU;
      win_addr_s = bus.ifu_rd_addr;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    rd_done_s   = (state_r == ST_WAIT_RD) && (lat_cnt_r == LAT_W'(1));
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) state_nxt_s = ST_ISSUE;
        else             state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (id_r == ID_EXWR) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (rd_done_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_WAIT_RD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, memory strobe, grant/valid pulses and the held read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      id_r              <= ID_IFU;
      lat_cnt_r         <= {LAT_W{1'b0}};
      wait_cnt_r        <= {WAIT_W{1'b0}};
      bus.busy          <= 1'b0;
      bus.mem_req       <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= {ADDR_WIDTH{1'b0}};
      bus.mem_wdata     <= {DATA_WIDTH{1'b0}};
      bus.ifu_rd_gnt    <= 1'b0;
      bus.exec_rd_gnt   <= 1'b0;
      bus.exec_wr_gnt   <= 1'b0;
      bus.ifu_rd_valid  <= 1'b0;
      bus.exec_rd_valid <= 1'b0;
      bus.ifu_rd_data   <= {DATA_WIDTH{1'b0}};
      bus.exec_rd_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r           <= state_nxt_s;
      bus.busy          <= (state_nxt_s != ST_IDLE);
      bus.mem_req       <= 1'b0;
      bus.ifu_rd_gnt    <= 1'b0;
      bus.exec_rd_gnt   <= 1'b0;
      bus.exec_wr_gnt   <= 1'b0;
      bus.ifu_rd_valid  <= 1'b0;
      bus.exec_rd_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            id_r            <= win_id_s;
            bus.mem_req     <= 1'b1;
            bus.mem_we      <= (win_id_s == ID_EXWR);
            bus.mem_addr    <= win_addr_s;
            bus.ifu_rd_gnt  <= (win_id_s == ID_IFU);
            bus.exec_rd_gnt <= (win_id_s == ID_EXRD);
            bus.exec_wr_gnt <= (win_id_s == ID_EXWR);
            if (win_id_s == ID_EXWR) bus.mem_wdata <= bus.exec_wr_data;
          end
          // Aging: only counts IDLE cycles where the IFU is waiting and loses.
          if (!bus.ifu_rd_req || (win_id_s == ID_IFU)) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else if (wait_cnt_r < WAIT_W'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_ISSUE: begin
          lat_cnt_r <= LAT_W'(RD_LATENCY);
        end
        ST_WAIT_RD: begin
          lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          if (rd_done_s) begin
            if (id_r == ID_IFU) begin
              bus.ifu_rd_data  <= bus.mem_rdata;
              bus.ifu_rd_valid <= 1'b1;
            end else begin
              bus.exec_rd_data  <= bus.mem_rdata;
              bus.exec_rd_valid <= 1'b1;
            end
          end
        end
        default: begin
          lat_cnt_r <= {LAT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef PDP_ARB_PERF_CNT_EN
  logic [1:0] req_cnt_s;

  // Number of requests present this cycle.
  always_comb begin
    req_cnt_s = {1'b0, bus.ifu_rd_req} + {1'b0, bus.exec_rd_req} + {1'b0, bus.exec_wr_req};
  end

  // Grant and IDLE-conflict counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifu_gnt_cnt     <= 32'd0;
      exec_rd_gnt_cnt <= 32'd0;
      exec_wr_gnt_cnt <= 32'd0;
      conflict_cnt    <= 32'd0;
    end else begin
      if (bus.ifu_rd_gnt)  ifu_gnt_cnt     <= ifu_gnt_cnt + 32'd1;
      if (bus.exec_rd_gnt) exec_rd_gnt_cnt <= exec_rd_gnt_cnt + 32'd1;
      if (bus.exec_wr_gnt) exec_wr_gnt_cnt <= exec_wr_gnt_cnt + 32'd1;
      if ((state_r == ST_IDLE) && (req_cnt_s >= 2'd2)) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
